// File: rtl/grid_io_tile_cfg.sv
// Perimeter I/O grid tile: NUM_IO GPIO subtiles configured through one serial shift chain,
// committed to a shadow register on cfg_done rise. Optional parity flop: GRID_IO_CHAIN_PARITY_EN.
module grid_io_tile_cfg #(
  parameter int unsigned NUM_IO          = 8,
  parameter int unsigned CFG_BITS_PER_IO = 2
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_done,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [0:NUM_IO-1] io_outpad,
  output logic [0:NUM_IO-1] io_inpad,
  inout  wire  [0:NUM_IO-1] gfpga_pad_GPIO_PAD,
  output logic              cfg_len_ok,
  output logic              cfg_overflow,
  output logic              cfg_parity_err
);

`ifdef GRID_IO_CHAIN_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif
  localparam int unsigned FieldBits = NUM_IO * CFG_BITS_PER_IO;
  localparam int unsigned CHAIN_LEN = FieldBits + ParBits;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CntLen = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [FieldBits-1:0] active_q, active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cfg_done_q;
  logic                 valid_q, valid_d;
  logic                 len_ok_q, len_ok_d;
  logic                 ovf_q, ovf_d;
  logic                 commit;
  logic                 par_ok;

  assign commit = cfg_done & ~cfg_done_q;

`ifdef GRID_IO_CHAIN_PARITY_EN
  logic perr_q;

  assign par_ok = ~^chain_q;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      perr_q <= 1'b0;
    end else if (commit) begin
      perr_q <= ~par_ok;
    end
  end

  assign cfg_parity_err = perr_q;
`else
  assign par_ok         = 1'b1;
  assign cfg_parity_err = 1'b0;
`endif

  always_comb begin
    chain_d  = chain_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    len_ok_d = len_ok_q;
    ovf_d    = ovf_q;
    if (!cfg_done) begin
      chain_d = {chain_q[CHAIN_LEN-2:0], ccff_head};
      valid_d = 1'b0;
      // A 1->0 transition opens a new session; this edge's shift is its first.
      if (cfg_done_q) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (commit) begin
      len_ok_d = (cnt_q == CntLen);
      ovf_d    = (cnt_q > CntLen);
      if (par_ok) begin
        active_d = chain_q[ParBits +: FieldBits];
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      chain_q    <= '0;
      active_q   <= '0;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
      valid_q    <= 1'b0;
      len_ok_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      chain_q    <= chain_d;
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      cfg_done_q <= cfg_done;
      valid_q    <= valid_d;
      len_ok_q   <= len_ok_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ccff_tail    = chain_q[CHAIN_LEN-1];
  assign cfg_len_ok   = len_ok_q;
  assign cfg_overflow = ovf_q;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    logic [2:0] fld;  // {OINV, IINV, DIR}, absent bits read as 0
    logic       drive;

    always_comb begin
      fld                        = '0;
      fld[CFG_BITS_PER_IO-1:0]   = active_q[i*CFG_BITS_PER_IO +: CFG_BITS_PER_IO];
    end

    assign drive                 = valid_q & fld[0];
    assign gfpga_pad_GPIO_PAD[i] = drive ? (io_outpad[i] ^ fld[2]) : 1'bz;
    assign io_inpad[i]           = (valid_q & ~fld[0]) ? (gfpga_pad_GPIO_PAD[i] ^ fld[1]) : 1'b0;
  end

endmodule
